hilo_mdu_ctrl: RTL
==================

// Module: hilo_mdu_ctrl
// PURPOSE
//  Iterative multiply/divide sequencer owning the HI/LO register pair of the pipelined MIPS core.
//  Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs one radix-2 step per cycle.
//  Raises a pipeline stall while a later MFHI/MFLO or mult/div would consume an unfinished result.
//  Sits beside the ALU; rd_data feeds the EX result mux in place of the single-cycle HI/LO path.
// PARAMETERS
//  WIDTH  32  operand width; also the number of iteration cycles
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous, active-low reset
//  start     in   1      EX holds a mult/div this cycle; sampled on the rising edge
//  op        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a         in   WIDTH  rs operand (multiplicand / dividend)
//  b         in   WIDTH  rt operand (multiplier / divisor)
//  flush     in   1      EX instruction squashed; abort in-flight op
//  rd_hilo   in   1      EX holds MFHI/MFLO this cycle
//  hilo_sel  in   1      0 selects LO, 1 selects HI for rd_data
//  busy      out  1      operation in flight (state != IDLE)
//  stall     out  1      busy & (start | rd_hilo); combinational; holds F/D/EX
//  done      out  1      one-cycle pulse; HI/LO just updated
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
//  rd_data   out  WIDTH  hilo_sel ? hi : lo; combinational from registers
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, count=0, hi=lo=0, busy=0, done=0; working regs cleared.
//  FSM: IDLE -> RUN on edge with start=1 & flush=0 & state=IDLE; operands latched.
//   RUN: WIDTH cycles, count 0..WIDTH-1; at count=WIDTH-1 -> SIGN.
//   SIGN: one cycle; sign fix-up applied; hi/lo written; -> IDLE; done=1 in the following cycle.
//  Latency: start sampled at edge T -> hi/lo valid and done=1 after edge T+WIDTH+1.
//   busy=1 after edges T..T+WIDTH; busy=0 in the done cycle.
//  Signed ops: operate on magnitudes; record sign(a) XOR sign(b) and sign(a).
//   MULT: 2*WIDTH product negated when signs differ; {hi,lo}=product.
//   DIV: quotient negated when signs differ; remainder takes sign of a; lo=quotient, hi=remainder.
//   Unsigned ops: no fix-up.
//  Multiply: shift-add, 2*WIDTH accumulator.
//  Divide: restoring shift-subtract, WIDTH+1-bit partial remainder.
//  Divide by zero (b=0): hi=a, lo=all ones, same latency, done pulses normally.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
//  start while busy: not accepted; stall=1 holds EX; accepted on the edge after the done cycle.
//  rd_hilo while busy: stall=1; rd_data stays the old HI/LO; caller must not consume it.
//  flush: the next edge forces IDLE, hi/lo unchanged, no done; flush beats start in the same cycle.
//  flush in the SIGN cycle: result discarded, hi/lo unchanged.
//  stall is never asserted in IDLE; done and busy are never both 1.
//  rst low mid-operation: immediate return to reset values; no partial write.
// TESTING
//  MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; done exactly WIDTH+1 edges after start edge.
//  MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; busy high for 33 cycles.
//  DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  DIVU 7/0 -> hi=7 lo=FFFFFFFF.
//  DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  rd_hilo=1 from edge T+1 -> stall=1 until done cycle, then rd_data equals new LO.
//  Back-to-back start -> second op latched on the edge after done.
//  flush at count=10 -> busy=0 next cycle, hi/lo keep prior values, done stays 0.
//  rst pulse mid-run -> hi=lo=0 and busy=0 asynchronously.

Source files
------------

// File: rtl/hilo_mdu_ctrl.sv
// Iterative MIPS multiply/divide unit owning HI/LO. It runs one radix-2 step per cycle
// and stalls the pipeline while a consumer would see an unfinished result.
module hilo_mdu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_hilo,
  input  logic             hilo_sel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StSign} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   add_op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply step: acc = {partial product, remaining multiplier bits}
  assign add_op = acc_q[0] ? opnd_q : '0;
  assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, add_op};

  // Divide step: the remainder is always below the divisor, so the
  // subtraction result fits in WIDTH bits.
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, opnd_q};
  assign rem_sub = shifted[WIDTH-1:0] - opnd_q;

  // A zero divisor leaves the quotient as all ones regardless of signs.
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = (neg_res_q && !dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d   = StRun;
          count_d   = '0;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[1] & (b == '0);
          rem_d     = '0;
          if (op[1]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            rem_d              = ge ? rem_sub : shifted[WIDTH-1:0];
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ge};
          end else begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
          end
          count_d = count_q + 1'b1;
          if (count_q == LastCnt) state_d = StSign;
        end
      end
      StSign: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign stall   = busy & (start | rd_hilo);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = hilo_sel ? hi_q : lo_q;

endmodule
